seg7_scan: RTL and testbench

Multiplexed four-digit seven-segment display driver that consumes the 4-bit BCD counts produced by the cascaded decade-counter stages and drives a common-anode display. It captures all four digits once per scan frame, time-multiplexes one digit per refresh slot, and decodes BCD to active-low segment patterns. It includes a guard (all-anodes-off) cycle at each slot boundary and optional leading-zero blanking.

---
 rtl/seg7_scan_if.sv | 17 +
 rtl/seg7_scan.sv | 59 +++++
 tb/tb_seg7_scan.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/seg7_scan_if.sv
// seg7_scan_if: digit/control inputs and display outputs of the seven-segment scanner.
interface seg7_scan_if;
    logic [3:0] bcd0;
    logic [3:0] bcd1;
    logic [3:0] bcd2;
    logic [3:0] bcd3;
    logic [3:0] dp_en;
    logic       lz_blank;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame_start;
    modport master (output bcd0, bcd1, bcd2, bcd3, dp_en, lz_blank,
                    input  an, seg, dp, frame_start);
    modport slave  (input  bcd0, bcd1, bcd2, bcd3, dp_en, lz_blank,
                    output an, seg, dp, frame_start);
endinterface

// File: rtl/seg7_scan.sv
// seg7_scan: four-digit multiplexed common-anode BCD display driver with a per-frame snapshot,
// a guard cycle at every slot boundary, and optional leading-zero blanking.
module seg7_scan #(
    parameter int REFRESH_DIV = 50000
) (
    input logic        clock,
    input logic        reset,
    seg7_scan_if.slave bus
);
    localparam int DW = $clog2(REFRESH_DIV);
    localparam logic [DW-1:0] D_LAST = DW'(REFRESH_DIV - 1);
    localparam logic [6:0] PAT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F
    };
    logic [DW-1:0] d;
    logic [1:0]    k;
    logic [3:0]    snap [4];
    logic [3:0]    snap_dp;
    logic [3:0]    zero;
    logic [3:0]    blank;
    logic          guard;
    logic [3:0]    an_next;
    logic [6:0]    seg_next;
    logic          dp_next;
    always_comb begin
        zero     = {snap[3] == 4'd0, snap[2] == 4'd0, snap[1] == 4'd0, snap[0] == 4'd0};
        blank    = {zero[3], &zero[3:2], &zero[3:1], 1'b0};
        guard    = d == '0;
        an_next  = guard ? 4'hF : ~(4'b0001 << k);
        seg_next = (guard || (bus.lz_blank && blank[k])) ? 7'h7F : PAT[snap[k]];
        dp_next  = guard ? 1'b1 : ~snap_dp[k];
    end
    // Capture happens on the guard cycle of slot 0, so a whole frame shows one coherent value.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            d               <= '0;
            k               <= '0;
            snap            <= '{default: '0};
            snap_dp         <= '0;
            bus.an          <= 4'hF;
            bus.seg         <= 7'h7F;
            bus.dp          <= 1'b1;
            bus.frame_start <= 1'b0;
        end else begin
            d <= (d == D_LAST) ? '0 : d + 1'b1;
            if (d == D_LAST)
                k <= k + 2'd1;
            if (guard && k == 2'd0) begin
                snap    <= '{bus.bcd0, bus.bcd1, bus.bcd2, bus.bcd3};
                snap_dp <= bus.dp_en;
            end
            bus.an          <= an_next;
            bus.seg         <= seg_next;
            bus.dp          <= dp_next;
            bus.frame_start <= guard && k == 2'd0;
        end
    end
endmodule

// File: tb/tb_seg7_scan.sv
// tb_seg7_scan: directed and random stimulus against a cycle-position model of the display scan.
module tb_seg7_scan;
    localparam int RD = 4;
    localparam int FR = 4 * RD;
    localparam logic [6:0] PAT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F
    };
    logic clock = 1'b0;
    logic reset = 1'b0;
    seg7_scan_if bus ();
    seg7_scan #(.REFRESH_DIV(RD)) dut (.clock(clock), .reset(reset), .bus(bus));
    always #5 clock = ~clock;

    int nvec = 0;
    int nerr = 0;
    int p = 0;
    logic [3:0] ms [4];
    logic [3:0] mdp;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: got %h want %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic leading_zero(input int i);
        logic z = 1'b1;
        for (int j = i; j < 4; j++) z = z && (ms[j] == 4'd0);
        return i > 0 && z;
    endfunction

    // p is the position within the frame before the edge: slot = p / RD, guard when p % RD == 0.
    task automatic step();
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp;
        logic       lz;
        int         kk;
        kk = p / RD;
        lz = bus.lz_blank;
        if (p == 0) begin
            ms  = '{bus.bcd0, bus.bcd1, bus.bcd2, bus.bcd3};
            mdp = bus.dp_en;
        end
        @(posedge clock);
        #1;
        if (p % RD == 0) begin
            e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
        end else begin
            e_an  = 4'hF & ~(4'(1) << kk);
            e_seg = (lz && leading_zero(kk)) ? 7'h7F : PAT[ms[kk]];
            e_dp  = ~mdp[kk];
        end
        chk("an", 8'(bus.an), 8'(e_an));
        chk("seg", 8'(bus.seg), 8'(e_seg));
        chk("dp", 8'(bus.dp), 8'(e_dp));
        chk("frame_start", 8'(bus.frame_start), 8'(p == 0));
        p = (p + 1) % FR;
    endtask

    task automatic frames(input int n);
        repeat (n * FR) step();
    endtask

    task automatic set_in(input logic [3:0] b3, b2, b1, b0, input logic [3:0] dpe, input logic lz);
        bus.bcd3 = b3; bus.bcd2 = b2; bus.bcd1 = b1; bus.bcd0 = b0;
        bus.dp_en = dpe; bus.lz_blank = lz;
    endtask

    task automatic guard_check(input string tag);
        chk({tag, "_an"}, 8'(bus.an), 8'h0F);
        chk({tag, "_seg"}, 8'(bus.seg), 8'h7F);
        chk({tag, "_dp"}, 8'(bus.dp), 8'h01);
        chk({tag, "_fs"}, 8'(bus.frame_start), 8'h00);
    endtask

    initial begin
        set_in(4'd1, 4'd2, 4'd3, 4'd4, 4'b0100, 1'b0);
        ms = '{default: '0};
        mdp = '0;
        #1 reset = 1'b1;
        #1 guard_check("rst");
        #10 reset = 1'b0;
        step();
        chk("first_fs", 8'(bus.frame_start), 8'h01);
        chk("first_guard", 8'(bus.an), 8'h0F);
        step();
        chk("second_an", 8'(bus.an), 8'h0E);
        chk("second_seg", 8'(bus.seg), 8'h19);
        repeat (FR - 2) step();
        frames(2);

        for (int c = 0; c < 16; c++) begin
            set_in(4'd1, 4'd0, 4'd7, 4'(c), 4'b0000, 1'b0);
            step();
            step();
            chk("decode", 8'(bus.seg), 8'(PAT[c]));
            repeat (FR - 2) step();
        end

        set_in(4'd0, 4'd0, 4'd4, 4'd0, 4'b1001, 1'b1);
        frames(1);
        set_in(4'd0, 4'd0, 4'd4, 4'd0, 4'b1001, 1'b0);
        frames(1);
        set_in(4'd0, 4'd0, 4'd0, 4'd0, 4'b0000, 1'b1);
        frames(1);
        set_in(4'd0, 4'd12, 4'd0, 4'd3, 4'b0010, 1'b1);
        frames(1);

        set_in(4'd8, 4'd6, 4'd5, 4'd2, 4'b0000, 1'b0);
        repeat (2) step();
        bus.bcd1 = 4'd9;
        repeat (FR - 2) step();
        frames(1);

        repeat (8 * FR) begin
            if ($urandom_range(0, 3) == 0)
                set_in(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)),
                       4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                       4'($urandom), 1'($urandom));
            step();
        end

        set_in(4'd3, 4'd1, 4'd4, 4'd1, 4'b0001, 1'b0);
        repeat (9) step();
        #2 reset = 1'b1;
        #1 guard_check("midrst");
        #1 reset = 1'b0;
        p = 0;
        ms = '{default: '0};
        mdp = '0;
        set_in(4'd5, 4'd9, 4'd2, 4'd6, 4'b1000, 1'b0);
        step();
        chk("restart_fs", 8'(bus.frame_start), 8'h01);
        repeat (FR - 1) step();
        frames(1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
